// File: rtl/bus_target.sv
// bus_target: register-file bus target for a single-master arbiter.
// A bus cycle is decoded against BASE_ADDR, held for WAIT_STATES clocks,
// then presented as ready until the arbiter strobes it, times it out
// (error) or drops address_valid. Writes land in a small register file
// that is also exported flat on reg_q.
module bus_target #(
   parameter               BASE_ADDR   = 16'h0100,
   parameter int unsigned  ADDR_WIDTH  = 16,
   parameter int unsigned  DATA_WIDTH  = 16,
   parameter int unsigned  REG_COUNT   = 8,
   parameter int unsigned  WAIT_STATES = 2,
   localparam int unsigned IDX_W       = $clog2(REG_COUNT)
) (
   input  logic                            clk,
   input  logic                            clrn,
   input  logic                            address_valid,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic                            wr,
   input  logic [DATA_WIDTH-1:0]           wdata,
   input  logic                            data_strobe,
   input  logic                            error,
   output logic                            target_ready,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            rdata_oe,
   output logic                            wr_pulse,
   output logic [IDX_W-1:0]                wr_index,
   output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
   output logic [7:0]                      err_cnt,
   output logic                            busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_READY  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_IGNORE = 3'd5;

   localparam logic [ADDR_WIDTH-1:0] BASE_L = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [3:0]            WAIT_L = 4'(WAIT_STATES);

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  armed_q, armed_d;
   logic                  target_ready_q, target_ready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_oe_q, rdata_oe_d;
   logic                  wr_pulse_q, wr_pulse_d;
   logic [IDX_W-1:0]      wr_index_q, wr_index_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

   logic             hit;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [7:0]       err_cnt_inc;

   assign hit         = (addr_q[ADDR_WIDTH-1:IDX_W] == BASE_L[ADDR_WIDTH-1:IDX_W]);
   assign idx_q       = addr_q[IDX_W-1:0];
   assign idx_d       = addr_d[IDX_W-1:0];
   assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   // Next-state, datapath and register-file update for the bus-cycle FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      armed_d    = armed_q | ~address_valid;
      rdata_d    = rdata_q;
      wr_pulse_d = 1'b0;
      wr_index_d = wr_index_q;
      err_cnt_d  = err_cnt_q;
      regs_d     = regs_q;

      case (state_q)
         S_IDLE: begin
            // armed_q guarantees address_valid was seen low since the last cycle or reset.
            if (address_valid && armed_q) begin
               state_d = S_DECODE;
               addr_d  = addr;
               wr_d    = wr;
               armed_d = 1'b0;
            end
         end
         S_DECODE: begin
            if (!address_valid) begin
               state_d = S_IDLE;
            end else if (hit) begin
               cnt_d   = WAIT_L;
               state_d = (WAIT_L == 4'd0) ? S_READY : S_WAIT;
            end else begin
               state_d = S_IGNORE;
            end
         end
         S_WAIT: begin
            if (!address_valid) begin
               state_d = S_IDLE;
            end else if (error) begin
               state_d   = S_DONE;
               err_cnt_d = err_cnt_inc;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_READY;
               end
            end
         end
         S_READY: begin
            // Abort outranks error, and error outranks a simultaneous strobe.
            if (!address_valid) begin
               state_d = S_IDLE;
            end else if (error) begin
               state_d   = S_DONE;
               err_cnt_d = err_cnt_inc;
            end else if (data_strobe) begin
               state_d = S_DONE;
               if (wr_q) begin
                  regs_d[idx_q] = wdata;
                  wr_pulse_d    = 1'b1;
                  wr_index_d    = idx_q;
               end
            end
         end
         S_DONE, S_IGNORE: begin
            if (!address_valid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered so target_ready/rdata_oe are glitch-free on the bus.
      target_ready_d = (state_d == S_READY);
      rdata_oe_d     = (state_d == S_READY) && !wr_d;
      if ((state_d == S_READY) && (state_q != S_READY)) begin
         rdata_d = regs_q[idx_d];
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         wr_q           <= 1'b0;
         cnt_q          <= 4'd0;
         armed_q        <= 1'b0;
         target_ready_q <= 1'b0;
         rdata_q        <= '0;
         rdata_oe_q     <= 1'b0;
         wr_pulse_q     <= 1'b0;
         wr_index_q     <= '0;
         err_cnt_q      <= 8'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
         state_q        <= state_d;
         addr_q         <= addr_d;
         wr_q           <= wr_d;
         cnt_q          <= cnt_d;
         armed_q        <= armed_d;
         target_ready_q <= target_ready_d;
         rdata_q        <= rdata_d;
         rdata_oe_q     <= rdata_oe_d;
         wr_pulse_q     <= wr_pulse_d;
         wr_index_q     <= wr_index_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   // Register file storage.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         // NOTE: the register file is reset because its contents are visible on reg_q and must read zero after reset.
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar g = 0; g < int'(REG_COUNT); g++) begin : g_flat
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   assign target_ready = target_ready_q;
   assign rdata        = rdata_q;
   assign rdata_oe     = rdata_oe_q;
   assign wr_pulse     = wr_pulse_q;
   assign wr_index     = wr_index_q;
   assign err_cnt      = err_cnt_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: directed checks of bus_target with default parameters
// (BASE 0x0100, 8 x 16-bit registers, 2 wait states).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_target;

   logic         clk;
   logic         clrn;
   logic         address_valid;
   logic [15:0]  addr;
   logic         wr;
   logic [15:0]  wdata;
   logic         data_strobe;
   logic         error;
   logic         target_ready;
   logic [15:0]  rdata;
   logic         rdata_oe;
   logic         wr_pulse;
   logic [2:0]   wr_index;
   logic [127:0] reg_q;
   logic [7:0]   err_cnt;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [127:0] exp_regs;
   int           lat;
   int           seen;

   bus_target dut (
      .clk          (clk),
      .clrn         (clrn),
      .address_valid(address_valid),
      .addr         (addr),
      .wr           (wr),
      .wdata        (wdata),
      .data_strobe  (data_strobe),
      .error        (error),
      .target_ready (target_ready),
      .rdata        (rdata),
      .rdata_oe     (rdata_oe),
      .wr_pulse     (wr_pulse),
      .wr_index     (wr_index),
      .reg_q        (reg_q),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts a bus cycle and waits (bounded) for target_ready; lat = falling edges waited.
   task automatic start_and_wait(input logic [15:0] a, input logic w, input logic [15:0] d, output int l);
      address_valid = 1'b1;
      addr          = a;
      wr            = w;
      wdata         = d;
      l             = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!target_ready && l < 20);
      check("ready_reached", {127'd0, target_ready}, 128'd1);
   endtask

   task automatic end_cycle();
      address_valid = 1'b0;
      data_strobe   = 1'b0;
      error         = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_timeout();
      start_and_wait(16'h0105, 1'b1, 16'h1234, lat);
      data_strobe = 1'b1;
      error       = 1'b1;
      @(negedge clk);
      end_cycle();
   endtask

   initial begin
      clrn          = 1'b0;
      address_valid = 1'b0;
      addr          = '0;
      wr            = 1'b0;
      wdata         = '0;
      data_strobe   = 1'b0;
      error         = 1'b0;
      exp_regs      = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {127'd0, target_ready}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_regs", reg_q, 128'd0);
      check("rst_err_cnt", {120'd0, err_cnt}, 128'd0);
      check("rst_rdata", {112'd0, rdata}, 128'd0);
      clrn = 1'b1;
      @(negedge clk);

      // Write 0xA5A5 to register 3
      start_and_wait(16'h0103, 1'b1, 16'hA5A5, lat);
      check("wr_latency", 128'(lat), 128'd4);
      check("wr_no_oe", {127'd0, rdata_oe}, 128'd0);
      repeat (3) @(negedge clk);
      check("wr_ready_held", {127'd0, target_ready}, 128'd1);
      check("wr_not_yet", reg_q, exp_regs);
      data_strobe = 1'b1;
      @(negedge clk);
      data_strobe = 1'b0;
      exp_regs[3*16 +: 16] = 16'hA5A5;
      check("wr_pulse", {127'd0, wr_pulse}, 128'd1);
      check("wr_index", {125'd0, wr_index}, 128'd3);
      check("wr_reg3", reg_q, exp_regs);
      check("wr_done_ready", {127'd0, target_ready}, 128'd0);
      check("wr_done_busy", {127'd0, busy}, 128'd1);
      @(negedge clk);
      check("wr_pulse_one", {127'd0, wr_pulse}, 128'd0);
      end_cycle();
      check("wr_idle", {127'd0, busy}, 128'd0);

      // Read register 3
      start_and_wait(16'h0103, 1'b0, 16'h0000, lat);
      check("rd_rdata", {112'd0, rdata}, 128'h0000_A5A5);
      check("rd_oe", {127'd0, rdata_oe}, 128'd1);
      @(negedge clk);
      check("rd_oe_held", {127'd0, rdata_oe}, 128'd1);
      data_strobe = 1'b1;
      @(negedge clk);
      data_strobe = 1'b0;
      check("rd_oe_off", {127'd0, rdata_oe}, 128'd0);
      check("rd_no_pulse", {127'd0, wr_pulse}, 128'd0);
      check("rd_regs", reg_q, exp_regs);
      end_cycle();

      // Miss at 0x0200, with strobe and error that must be ignored
      address_valid = 1'b1;
      addr          = 16'h0200;
      wr            = 1'b1;
      wdata         = 16'h7777;
      seen          = 0;
      for (int i = 0; i < 10; i++) begin
         data_strobe = (i == 5);
         error       = (i == 5);
         @(negedge clk);
         if (target_ready || rdata_oe) seen++;
      end
      data_strobe = 1'b0;
      error       = 1'b0;
      check("miss_no_ready", 128'(seen), 128'd0);
      check("miss_busy", {127'd0, busy}, 128'd1);
      check("miss_err_cnt", {120'd0, err_cnt}, 128'd0);
      check("miss_regs", reg_q, exp_regs);
      end_cycle();
      check("miss_idle", {127'd0, busy}, 128'd0);

      // Timeout: error together with strobe in READY
      start_and_wait(16'h0105, 1'b1, 16'h1234, lat);
      data_strobe = 1'b1;
      error       = 1'b1;
      @(negedge clk);
      data_strobe = 1'b0;
      error       = 1'b0;
      check("to_err_cnt", {120'd0, err_cnt}, 128'd1);
      check("to_no_pulse", {127'd0, wr_pulse}, 128'd0);
      check("to_regs", reg_q, exp_regs);
      check("to_done_busy", {127'd0, busy}, 128'd1);
      end_cycle();

      // Abort in WAIT
      address_valid = 1'b1;
      addr          = 16'h0102;
      wr            = 1'b1;
      wdata         = 16'hFFFF;
      repeat (2) @(negedge clk);
      check("ab_wait_busy", {127'd0, busy}, 128'd1);
      address_valid = 1'b0;
      @(negedge clk);
      check("ab_idle", {127'd0, busy}, 128'd0);
      check("ab_regs", reg_q, exp_regs);
      check("ab_err_cnt", {120'd0, err_cnt}, 128'd1);
      check("ab_no_pulse", {127'd0, wr_pulse}, 128'd0);
      @(negedge clk);

      // Saturation of err_cnt
      for (int i = 0; i < 254; i++) do_timeout();
      check("sat_255", {120'd0, err_cnt}, 128'd255);
      do_timeout();
      check("sat_hold", {120'd0, err_cnt}, 128'd255);

      // Reset while READY on a pending write
      start_and_wait(16'h0106, 1'b1, 16'h5555, lat);
      data_strobe = 1'b1;
      clrn        = 1'b0;
      #1;
      check("rr_ready", {127'd0, target_ready}, 128'd0);
      check("rr_busy", {127'd0, busy}, 128'd0);
      check("rr_regs", reg_q, 128'd0);
      check("rr_err_cnt", {120'd0, err_cnt}, 128'd0);
      @(negedge clk);
      data_strobe = 1'b0;
      clrn        = 1'b1;
      seen        = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy || wr_pulse) seen++;
      end
      check("rr_wait_low", 128'(seen), 128'd0);
      exp_regs = '0;
      end_cycle();

      // Read after reset returns zero
      start_and_wait(16'h0103, 1'b0, 16'h0000, lat);
      check("pr_oe", {127'd0, rdata_oe}, 128'd1);
      check("pr_rdata", {112'd0, rdata}, 128'd0);
      end_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_target.md
BUS_TARGET -- requirements
Module: bus_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0100, meaning the target's base address; the low IDX_W bits SHALL be zero.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning the bus data width.
REQ-004 SHALL have parameter REG_COUNT, default 8, meaning the register count (power of 2); IDX_W = log2(REG_COUNT).
REQ-005 SHALL have parameter WAIT_STATES, default 2, meaning the cycles between decode and target_ready (0..15).
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port clrn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port address_valid, input, 1 bit: the arbiter's bus cycle is active; addr and wr are stable while it is high.
REQ-009 SHALL have port addr, input, ADDR_WIDTH bits: the bus address.
REQ-010 SHALL have port wr, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port data_strobe, input, 1 bit: the arbiter's one-clock transfer strobe.
REQ-013 SHALL have port error, input, 1 bit: the arbiter's one-clock timeout pulse.
REQ-014 SHALL have port target_ready, output, 1 bit: address decoded and data path ready (feeds the arbiter's TargetReady).
REQ-015 SHALL have port rdata, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port rdata_oe, output, 1 bit: rdata is valid and may be driven onto the bus.
REQ-017 SHALL have port wr_pulse, output, 1 bit: one clock high when a register is written.
REQ-018 SHALL have port wr_index, output, IDX_W bits: the index of the register written.
REQ-019 SHALL have port reg_q, output, REG_COUNT*DATA_WIDTH bits: flat register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-020 SHALL have port err_cnt, output, 8 bits: saturating count of aborted hit cycles.
REQ-021 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, DECODE, WAIT, READY, DONE, IGNORE.
REQ-023 IDLE -> DECODE SHALL occur when address_valid=1; DECODE SHALL latch addr and wr and last exactly one cycle.
REQ-024 hit SHALL be defined as addr[ADDR_WIDTH-1:IDX_W] == BASE_ADDR[ADDR_WIDTH-1:IDX_W]; DECODE -> WAIT on hit (load counter with WAIT_STATES), else -> IGNORE.
REQ-025 WAIT SHALL decrement the counter each cycle and go -> READY when it is 0; with WAIT_STATES=0, target_ready SHALL assert the cycle after DECODE.
REQ-026 target_ready SHALL be registered and high only in READY; rdata SHALL equal reg[latched index] from READY entry; rdata_oe = READY & ~wr_latched.
REQ-027 In READY, data_strobe=1 with error=0 SHALL write wdata (sampled that cycle) to reg[index] if wr_latched, pulse wr_pulse/wr_index the next cycle, and go -> DONE.
REQ-028 error=1 in WAIT or READY SHALL go -> DONE with no write and err_cnt+1, saturating at 255; error beats a simultaneous data_strobe.
REQ-029 DONE and IGNORE SHALL return -> IDLE when address_valid=0; no new cycle SHALL start until address_valid has been low for at least one clock.
REQ-030 address_valid=0 in DECODE, WAIT or READY SHALL abort -> IDLE with no write and no err_cnt change.
REQ-031 data_strobe or error outside WAIT/READY SHALL be ignored; IGNORE SHALL never assert target_ready or rdata_oe.
REQ-032 Reads SHALL have no side effects.

Reset
REQ-033 clrn=0 SHALL immediately force IDLE; target_ready, rdata_oe, wr_pulse and busy = 0; rdata, wr_index, all registers and err_cnt = 0; counter = 0.
REQ-034 Reset asserted mid-cycle SHALL discard the cycle; after release the block SHALL wait for address_valid=0 before accepting a new cycle.

Verification
REQ-035 Write: BASE 0x0100, addr=0x0103, wr=1, wdata=0xA5A5, strobe 3 clocks after target_ready -> target_ready 4 clocks after address_valid rises, reg3=0xA5A5, wr_pulse one clock with wr_index=3.
REQ-036 Read: addr=0x0103, wr=0 -> rdata=0xA5A5 and rdata_oe=1 while in READY, registers unchanged.
REQ-037 Miss: addr=0x0200 -> target_ready never asserts, busy stays 1 until address_valid falls.
REQ-038 Timeout: hit write with error pulsed in READY together with data_strobe -> no write, err_cnt=1; 256 timeouts -> err_cnt=255.
REQ-039 Abort: address_valid dropped during WAIT -> IDLE next clock, no write, err_cnt unchanged.
REQ-040 clrn low during READY -> outputs zero immediately, reg_q all zero, no wr_pulse.
